// File: rtl/test_mon_pkg.sv
// Shared types and constants for the test_result_monitor pass/fail snooper.
package test_mon_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  localparam logic [ADDR_W-1:0] GPR_DONE_IDX = 5'd26;
  localparam logic [ADDR_W-1:0] GPR_SIG_IDX  = 5'd27;

  localparam logic [DATA_W-1:0] DEFAULT_PASS_CODE = 32'd1;

  typedef enum logic [1:0] {
    MON_RUN     = 2'd0,
    MON_PASS    = 2'd1,
    MON_FAIL    = 2'd2,
    MON_TIMEOUT = 2'd3
  } mon_state_e;

endpackage

// File: rtl/test_result_monitor.sv
// Snoops the GPR write port and derives a registered test verdict from x26/x27.
// Watchdog is compiled in only when TEST_MON_TIMEOUT_EN is defined.
module test_result_monitor
  import test_mon_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000,
  parameter logic [31:0] PASS_CODE      = DEFAULT_PASS_CODE
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ndmreset_i,
  input  logic        gpr_we_i,
  input  logic [4:0]  gpr_waddr_i,
  input  logic [31:0] gpr_wdata_i,
  output logic        done_o,
  output logic        pass_o,
  output logic        fail_o,
  output logic        timeout_o,
  output logic        result_valid_o,
  output logic [31:0] cycles_o,
  output logic [31:0] sig_o
);

  mon_state_e        state_q, state_d;
  logic [DATA_W-1:0] x26_q, x26_d;
  logic [DATA_W-1:0] x27_q, x27_d;
  logic [DATA_W-1:0] cycles_q, cycles_d;
  logic [DATA_W-1:0] sig_q, sig_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              fail_q, fail_d;
  logic              valid_q, valid_d;
  logic              trigger_c;
  logic              wdog_hit_c;

  assign trigger_c = gpr_we_i && (gpr_waddr_i == GPR_DONE_IDX)
                     && (gpr_wdata_i == PASS_CODE);

`ifdef TEST_MON_TIMEOUT_EN
  logic timeout_q, timeout_d;

  assign wdog_hit_c = (cycles_q == (TIMEOUT_CYCLES - 32'd1));
  assign timeout_d  = (state_d == MON_TIMEOUT);
  assign timeout_o  = timeout_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end
`else
  // Parameter kept in the interface so both builds share one instantiation.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign wdog_hit_c = 1'b0;
  assign timeout_o  = 1'b0;
`endif

  // Next-state, shadow, counter and output decode.
  always_comb begin
    state_d  = state_q;
    x26_d    = x26_q;
    x27_d    = x27_q;
    cycles_d = cycles_q;
    sig_d    = sig_q;

    if (ndmreset_i) begin
      state_d  = MON_RUN;
      x26_d    = '0;
      x27_d    = '0;
      cycles_d = '0;
      sig_d    = '0;
    end else if (state_q == MON_RUN) begin
      if (gpr_we_i && (gpr_waddr_i == GPR_DONE_IDX)) x26_d = gpr_wdata_i;
      if (gpr_we_i && (gpr_waddr_i == GPR_SIG_IDX))  x27_d = gpr_wdata_i;
      if (cycles_q != '1) cycles_d = cycles_q + 32'd1;
      // A trigger landing on the watchdog's last cycle still yields a real verdict.
      if (trigger_c) begin
        state_d = (x27_q == PASS_CODE) ? MON_PASS : MON_FAIL;
        sig_d   = x27_q;
      end else if (wdog_hit_c) begin
        state_d = MON_TIMEOUT;
      end
    end

    done_d  = (state_d != MON_RUN);
    pass_d  = (state_d == MON_PASS);
    fail_d  = (state_d == MON_FAIL);
    valid_d = (state_q == MON_RUN) && (state_d != MON_RUN);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= MON_RUN;
      x26_q    <= '0;
      x27_q    <= '0;
      cycles_q <= '0;
      sig_q    <= '0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      fail_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      x26_q    <= x26_d;
      x27_q    <= x27_d;
      cycles_q <= cycles_d;
      sig_q    <= sig_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      valid_q  <= valid_d;
    end
  end

  assign done_o         = done_q;
  assign pass_o         = pass_q;
  assign fail_o         = fail_q;
  assign result_valid_o = valid_q;
  assign cycles_o       = cycles_q;
  assign sig_o          = sig_q;

endmodule

// File: tb/tb_test_result_monitor.sv
// Scoreboard bench for test_result_monitor: verdicts, restart, async reset, watchdog.
module tb_test_result_monitor;

  localparam logic [31:0] TMO = 32'd50;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        ndmreset_i = 1'b0;
  logic        gpr_we_i = 1'b0;
  logic [4:0]  gpr_waddr_i = 5'd0;
  logic [31:0] gpr_wdata_i = 32'd0;
  logic        done_o, pass_o, fail_o, timeout_o, result_valid_o;
  logic [31:0] cycles_o, sig_o;

  typedef struct {
    logic        pass;
    logic        fail;
    logic        tmo;
    logic [31:0] sig;
    logic [31:0] cyc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;

  test_result_monitor #(.TIMEOUT_CYCLES(TMO), .PASS_CODE(32'd1)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .ndmreset_i     (ndmreset_i),
    .gpr_we_i       (gpr_we_i),
    .gpr_waddr_i    (gpr_waddr_i),
    .gpr_wdata_i    (gpr_wdata_i),
    .done_o         (done_o),
    .pass_o         (pass_o),
    .fail_o         (fail_o),
    .timeout_o      (timeout_o),
    .result_valid_o (result_valid_o),
    .cycles_o       (cycles_o),
    .sig_o          (sig_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
    edge_cnt++;
  endtask

  task automatic gpr_write(input logic [4:0] a, input logic [31:0] d);
    gpr_we_i    = 1'b1;
    gpr_waddr_i = a;
    gpr_wdata_i = d;
    tick();
    gpr_we_i    = 1'b0;
  endtask

  task automatic idle_until(input int n);
    while (edge_cnt < n) tick();
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    gpr_we_i = 1'b0;
    ndmreset_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    edge_cnt = 0;
  endtask

  task automatic push_exp(input logic p, input logic f, input logic t,
                          input logic [31:0] s, input logic [31:0] c);
    exp_t e;
    e.pass = p; e.fail = f; e.tmo = t; e.sig = s; e.cyc = c;
    sb_q.push_back(e);
  endtask

  // Waits (bounded) for a verdict pulse, pops the scoreboard and checks pulse width.
  task automatic consume_verdict(input int budget, input string name);
    int   waited;
    exp_t e;
    waited = 0;
    while (result_valid_o !== 1'b1 && waited < budget) begin
      tick();
      waited++;
    end
    checks++;
    if (result_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL %s no_verdict result_valid_o=%b want 1", name, result_valid_o);
      sb_q.delete();
      return;
    end
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s unexpected_verdict queue empty", name);
      return;
    end
    e = sb_q.pop_front();
    checks++;
    if ({done_o, pass_o, fail_o, timeout_o} !== {1'b1, e.pass, e.fail, e.tmo}) begin
      errors++;
      $display("FAIL %s flags got %b%b%b%b want 1%b%b%b", name,
               done_o, pass_o, fail_o, timeout_o, e.pass, e.fail, e.tmo);
    end
    checks++;
    if (sig_o !== e.sig) begin
      errors++;
      $display("FAIL %s sig got %0h want %0h", name, sig_o, e.sig);
    end
    checks++;
    if (cycles_o !== e.cyc) begin
      errors++;
      $display("FAIL %s cycles got %0d want %0d", name, cycles_o, e.cyc);
    end
    // Terminal: a further write and an extra edge must change nothing.
    gpr_write(5'd26, 32'd1);
    tick();
    checks++;
    if (result_valid_o !== 1'b0 || done_o !== 1'b1 || pass_o !== e.pass
        || fail_o !== e.fail || cycles_o !== e.cyc || sig_o !== e.sig) begin
      errors++;
      $display("FAIL %s hold rv=%b done=%b pass=%b fail=%b cyc=%0d sig=%0h want rv=0 done=1 pass=%b fail=%b cyc=%0d sig=%0h",
               name, result_valid_o, done_o, pass_o, fail_o, cycles_o, sig_o,
               e.pass, e.fail, e.cyc, e.sig);
    end
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    checks++;
    if ({done_o, pass_o, fail_o, timeout_o, result_valid_o} !== 5'b0
        || cycles_o !== 32'd0 || sig_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_state flags=%b cyc=%0d sig=%0h want 0",
               {done_o, pass_o, fail_o, timeout_o, result_valid_o}, cycles_o, sig_o);
    end
  endtask

  task automatic test_pass();
    do_reset();
    gpr_write(5'd27, 32'd1);
    idle_until(10);
    push_exp(1'b1, 1'b0, 1'b0, 32'd1, 32'(edge_cnt + 1));
    gpr_write(5'd26, 32'd1);
    consume_verdict(4, "pass");
  endtask

  task automatic test_fail();
    do_reset();
    gpr_write(5'd27, 32'h0000_0003);
    tick();
    push_exp(1'b0, 1'b1, 1'b0, 32'd3, 32'(edge_cnt + 1));
    gpr_write(5'd26, 32'd1);
    consume_verdict(4, "fail");
  endtask

  task automatic test_non_trigger();
    do_reset();
    gpr_write(5'd27, 32'd1);
    gpr_write(5'd26, 32'd2);
    tick();
    checks++;
    if (done_o !== 1'b0 || result_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL non_trigger done=%b rv=%b want 0 0", done_o, result_valid_o);
    end
    push_exp(1'b1, 1'b0, 1'b0, 32'd1, 32'(edge_cnt + 1));
    gpr_write(5'd26, 32'd1);
    consume_verdict(4, "non_trigger_then_pass");
  endtask

  task automatic test_timeout();
    do_reset();
`ifdef TEST_MON_TIMEOUT_EN
    push_exp(1'b0, 1'b0, 1'b1, 32'd0, TMO);
    consume_verdict(60, "timeout");
`else
    idle_until(60);
    checks++;
    if (timeout_o !== 1'b0 || done_o !== 1'b0 || cycles_o !== 32'd60) begin
      errors++;
      $display("FAIL no_watchdog timeout=%b done=%b cyc=%0d want 0 0 60",
               timeout_o, done_o, cycles_o);
    end
`endif
    do_reset();
    gpr_write(5'd27, 32'd1);
    idle_until(49);
    push_exp(1'b1, 1'b0, 1'b0, 32'd1, 32'(edge_cnt + 1));
    gpr_write(5'd26, 32'd1);
    consume_verdict(4, "trigger_beats_timeout");
  endtask

  task automatic test_ndmreset();
    do_reset();
    gpr_write(5'd27, 32'd1);
    push_exp(1'b1, 1'b0, 1'b0, 32'd1, 32'(edge_cnt + 1));
    gpr_write(5'd26, 32'd1);
    consume_verdict(4, "pre_restart_pass");
    ndmreset_i = 1'b1;
    tick();
    ndmreset_i = 1'b0;
    edge_cnt = 0;
    checks++;
    if ({done_o, pass_o, fail_o, timeout_o, result_valid_o} !== 5'b0
        || cycles_o !== 32'd0 || sig_o !== 32'd0) begin
      errors++;
      $display("FAIL ndmreset_clear flags=%b cyc=%0d sig=%0h want 0",
               {done_o, pass_o, fail_o, timeout_o, result_valid_o}, cycles_o, sig_o);
    end
    gpr_write(5'd27, 32'd5);
    push_exp(1'b0, 1'b1, 1'b0, 32'd5, 32'(edge_cnt + 1));
    gpr_write(5'd26, 32'd1);
    consume_verdict(4, "post_restart_fail");
    // Restart coinciding with a trigger: restart wins and the x27 shadow is cleared.
    do_reset();
    gpr_write(5'd27, 32'd1);
    ndmreset_i = 1'b1;
    gpr_write(5'd26, 32'd1);
    ndmreset_i = 1'b0;
    edge_cnt = 0;
    checks++;
    if (done_o !== 1'b0 || result_valid_o !== 1'b0 || cycles_o !== 32'd0) begin
      errors++;
      $display("FAIL ndm_priority done=%b rv=%b cyc=%0d want 0 0 0",
               done_o, result_valid_o, cycles_o);
    end
    push_exp(1'b0, 1'b1, 1'b0, 32'd0, 32'(edge_cnt + 1));
    gpr_write(5'd26, 32'd1);
    consume_verdict(4, "shadow_cleared_fail");
  endtask

  task automatic test_async_reset();
    do_reset();
    idle_until(20);
    checks++;
    if (cycles_o !== 32'd20) begin
      errors++;
      $display("FAIL pre_async_cycles got %0d want 20", cycles_o);
    end
    #2;
    rst_i = 1'b1;
    #1;
    checks++;
    if ({done_o, pass_o, fail_o, timeout_o, result_valid_o} !== 5'b0
        || cycles_o !== 32'd0 || sig_o !== 32'd0) begin
      errors++;
      $display("FAIL async_reset flags=%b cyc=%0d sig=%0h want 0",
               {done_o, pass_o, fail_o, timeout_o, result_valid_o}, cycles_o, sig_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    edge_cnt = 0;
    tick();
    checks++;
    if (cycles_o !== 32'd1) begin
      errors++;
      $display("FAIL async_restart_count got %0d want 1", cycles_o);
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail();
    test_non_trigger();
    test_timeout();
    test_ndmreset();
    test_async_reset();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d entries want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit reached want finish earlier");
    $fatal(1, "bench time limit");
  end

endmodule
